// File: rtl/block_mem_responder_if.sv
// Cache-to-memory block request/response bundle.
// The cache is the master side; the backing memory is the slave side.
interface block_mem_responder_if #(
   parameter int unsigned c_line_size  = 32,
   parameter int unsigned c_block_size = 2,
   parameter int unsigned address_size = 32
);
   localparam int unsigned BLK_W  = (1 << c_block_size) * c_line_size;
   localparam int unsigned ADDR_W = address_size - c_block_size - 2;

   logic              m_read_i;
   logic              m_wr_i;
   logic [ADDR_W-1:0] m_address_i;
   logic [BLK_W-1:0]  m_write_data_i;
   logic [BLK_W-1:0]  m_read_data_o;
   logic              m_busywait_o;
   logic              m_read_done_o;
   logic              m_write_done_o;

   modport master (
      output m_read_i, m_wr_i, m_address_i, m_write_data_i,
      input  m_read_data_o, m_busywait_o, m_read_done_o, m_write_done_o
   );

   modport slave (
      input  m_read_i, m_wr_i, m_address_i, m_write_data_i,
      output m_read_data_o, m_busywait_o, m_read_done_o, m_write_done_o
   );
endinterface

// File: rtl/block_mem_responder.sv
// Fixed-latency block memory answering cache miss and write-back requests.
// Processes one access at a time; writes win over simultaneous reads.
module block_mem_responder #(
   parameter int unsigned c_line_size    = 32,
   parameter int unsigned c_block_size   = 2,
   parameter int unsigned address_size   = 32,
   parameter int unsigned mem_depth_log2 = 6,
   parameter int unsigned access_latency = 4
) (
   input logic                 clk_i,
   input logic                 reset_i,
   block_mem_responder_if.slave bus
);
   localparam int unsigned BLK_W = (1 << c_block_size) * c_line_size;
   localparam int unsigned IDX_W = mem_depth_log2;
   localparam int unsigned DEPTH = 1 << mem_depth_log2;
   localparam int unsigned CNT_W = (access_latency > 1) ? $clog2(access_latency) : 1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      READ_BUSY  = 2'd1,
      WRITE_BUSY = 2'd2,
      DONE       = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [BLK_W-1:0] wdata_q, wdata_d;
   logic [BLK_W-1:0] rdata_q, rdata_d;
   logic             busy_q, busy_d;
   logic             rdone_q, rdone_d;
   logic             wdone_q, wdone_d;
   logic [BLK_W-1:0] mem_q [DEPTH];
   logic [BLK_W-1:0] mem_d [DEPTH];

   // Next-state, storage update and registered output values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      busy_d  = 1'b0;
      rdone_d = 1'b0;
      wdone_d = 1'b0;
      mem_d   = mem_q;

      case (state_q)
         IDLE: begin
            if (bus.m_wr_i) begin
               idx_d   = bus.m_address_i[IDX_W-1:0];
               wdata_d = bus.m_write_data_i;
               cnt_d   = CNT_W'(access_latency - 1);
               busy_d  = 1'b1;
               state_d = WRITE_BUSY;
            end else if (bus.m_read_i) begin
               idx_d   = bus.m_address_i[IDX_W-1:0];
               cnt_d   = CNT_W'(access_latency - 1);
               busy_d  = 1'b1;
               state_d = READ_BUSY;
            end
         end
         READ_BUSY, WRITE_BUSY: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               if (state_q == WRITE_BUSY) begin
                  mem_d[idx_q] = wdata_q;
                  wdone_d      = 1'b1;
               end else begin
                  rdata_d = mem_q[idx_q];
                  rdone_d = 1'b1;
               end
            end else begin
               cnt_d  = cnt_q - CNT_W'(1);
               busy_d = 1'b1;
            end
         end
         DONE: begin
            // Requests present here are deliberately left for the next IDLE cycle
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         rdone_q <= 1'b0;
         wdone_q <= 1'b0;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         rdone_q <= rdone_d;
         wdone_q <= wdone_d;
         mem_q   <= mem_d;
      end
   end

   assign bus.m_read_data_o  = rdata_q;
   assign bus.m_busywait_o   = busy_q;
   assign bus.m_read_done_o  = rdone_q;
   assign bus.m_write_done_o = wdone_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Self-checking bench for block_mem_responder: vector table plus corner-case sequences,
// with a completion scoreboard fed at request time and drained on done strobes.
module tb_block_mem_responder;
   localparam int unsigned LAT    = 4;
   localparam int unsigned BLK_W  = 128;
   localparam int unsigned ADDR_W = 28;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   block_mem_responder_if #(.c_line_size(32), .c_block_size(2), .address_size(32)) bus ();

   block_mem_responder #(
      .c_line_size(32), .c_block_size(2), .address_size(32),
      .mem_depth_log2(6), .access_latency(LAT)
   ) dut (
      .clk_i  (clk),
      .reset_i(rst_n),
      .bus    (bus.slave)
   );

   typedef struct {
      logic             is_wr;
      logic [BLK_W-1:0] data;
   } exp_t;

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [BLK_W-1:0]  wdata;
      logic [BLK_W-1:0]  exp_rdata;
   } vec_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   logic [BLK_W-1:0] last_rd = '0;

   task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every done strobe must match the oldest outstanding request
   always @(negedge clk) begin
      if (!rst_n) begin
         last_rd = '0;
      end else if (bus.m_read_done_o || bus.m_write_done_o) begin
         exp_t e;
         chk("strobe_exclusive", BLK_W'(bus.m_read_done_o & bus.m_write_done_o), '0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: rd=%b wr=%b with no request outstanding (t=%0t)",
                     bus.m_read_done_o, bus.m_write_done_o, $time);
         end else begin
            e = sb.pop_front();
            chk("done_kind", BLK_W'(bus.m_write_done_o), BLK_W'(e.is_wr));
            if (e.is_wr) begin
               chk("rdata_hold_on_write", bus.m_read_data_o, last_rd);
            end else begin
               chk("read_data", bus.m_read_data_o, e.data);
               last_rd = e.data;
            end
         end
      end
   end

   // Busy for LAT cycles after the sampling edge, then one done cycle
   task automatic wait_access(input logic is_wr);
      for (int i = 0; i < int'(LAT); i++) begin
         @(negedge clk);
         chk("busy_high", BLK_W'(bus.m_busywait_o), BLK_W'(1));
         chk("no_early_done", BLK_W'(bus.m_read_done_o | bus.m_write_done_o), '0);
      end
      @(negedge clk);
      chk("busy_low_in_done", BLK_W'(bus.m_busywait_o), '0);
      chk("done_strobe", BLK_W'(is_wr ? bus.m_write_done_o : bus.m_read_done_o), BLK_W'(1));
   endtask

   task automatic access(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [BLK_W-1:0] wdata, input logic [BLK_W-1:0] exp_rdata);
      exp_t e;
      @(negedge clk);
      bus.m_wr_i           = wr;
      bus.m_read_i         = ~wr;
      bus.m_address_i      = addr;
      bus.m_write_data_i   = wdata;
      e.is_wr              = wr;
      e.data               = exp_rdata;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.m_wr_i   = 1'b0;
      bus.m_read_i = 1'b0;
      wait_access(wr);
   endtask

   vec_t vecs[8];

   initial begin
      logic [BLK_W-1:0] d1, pa, p5, pf, px, py;
      exp_t e;
      d1 = 128'h44444444_33333333_22222222_11111111;
      pa = {32{4'hA}};
      p5 = {32{4'h5}};
      pf = {32{4'hF}};
      px = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      py = 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD;

      vecs[0] = '{wr: 1'b0, addr: 28'h0000005, wdata: '0, exp_rdata: '0};
      vecs[1] = '{wr: 1'b1, addr: 28'h0000005, wdata: d1, exp_rdata: '0};
      vecs[2] = '{wr: 1'b0, addr: 28'h0000005, wdata: '0, exp_rdata: d1};
      vecs[3] = '{wr: 1'b1, addr: 28'h0000003, wdata: pa, exp_rdata: '0};
      vecs[4] = '{wr: 1'b0, addr: 28'h0000043, wdata: '0, exp_rdata: pa};
      vecs[5] = '{wr: 1'b1, addr: 28'h000003F, wdata: px, exp_rdata: '0};
      vecs[6] = '{wr: 1'b0, addr: 28'hFFFFFFF, wdata: '0, exp_rdata: px};
      vecs[7] = '{wr: 1'b0, addr: 28'h0000000, wdata: '0, exp_rdata: '0};

      bus.m_read_i       = 1'b0;
      bus.m_wr_i         = 1'b0;
      bus.m_address_i    = '0;
      bus.m_write_data_i = '0;

      #1;
      chk("reset_busy", BLK_W'(bus.m_busywait_o), '0);
      chk("reset_rdone", BLK_W'(bus.m_read_done_o), '0);
      chk("reset_wdone", BLK_W'(bus.m_write_done_o), '0);
      chk("reset_rdata", bus.m_read_data_o, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

      // Simultaneous write and read: write first, read held and taken after DONE
      @(negedge clk);
      bus.m_wr_i         = 1'b1;
      bus.m_read_i       = 1'b1;
      bus.m_address_i    = 28'h0000007;
      bus.m_write_data_i = p5;
      e = '{is_wr: 1'b1, data: '0};
      sb.push_back(e);
      e = '{is_wr: 1'b0, data: p5};
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.m_wr_i = 1'b0;
      wait_access(1'b1);
      chk("dual_no_read_done", BLK_W'(bus.m_read_done_o), '0);
      @(negedge clk);
      chk("dual_idle_busy", BLK_W'(bus.m_busywait_o), '0);
      chk("dual_idle_strobes", BLK_W'(bus.m_read_done_o | bus.m_write_done_o), '0);
      @(posedge clk);
      #1;
      bus.m_read_i = 1'b0;
      wait_access(1'b0);

      // Address and data changes during WRITE_BUSY are ignored
      @(negedge clk);
      bus.m_wr_i         = 1'b1;
      bus.m_address_i    = 28'h0000012;
      bus.m_write_data_i = px;
      e = '{is_wr: 1'b1, data: '0};
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.m_wr_i         = 1'b0;
      bus.m_address_i    = 28'h0000013;
      bus.m_write_data_i = py;
      wait_access(1'b1);
      access(1'b0, 28'h0000012, '0, px);
      access(1'b0, 28'h0000013, '0, '0);

      // Reset in the second busy cycle of a write aborts it
      @(negedge clk);
      bus.m_wr_i         = 1'b1;
      bus.m_address_i    = 28'h0000009;
      bus.m_write_data_i = pf;
      @(posedge clk);
      #1;
      bus.m_wr_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_busy", BLK_W'(bus.m_busywait_o), BLK_W'(1));
      rst_n = 1'b0;
      #1;
      chk("abort_busy", BLK_W'(bus.m_busywait_o), '0);
      chk("abort_strobes", BLK_W'(bus.m_read_done_o | bus.m_write_done_o), '0);
      chk("abort_rdata", bus.m_read_data_o, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      access(1'b0, 28'h0000009, '0, '0);
      access(1'b0, 28'h0000005, '0, '0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", BLK_W'(sb.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
